// File: rtl/mult_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mult_ctrl: shift-add sequencer for an external 4x4 product register.  |
// | Optional start_err output under MULT_CTRL_START_ERR_EN. Rev 1.0       |
// +-----------------------------------------------------------------------+
module mult_ctrl (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [3:0] mplr,
  input  logic [3:0] mcand,
  input  logic [3:0] acc_hi,
  output logic       ldp,
  output logic       shp,
  output logic [3:0] p_in,
  output logic       c_in,
  output logic       busy,
  output logic       done
`ifdef MULT_CTRL_START_ERR_EN
  ,
  output logic       start_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WAIT  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q;
  logic [3:0]  q_q;
  logic [3:0]  m_q;
  logic [1:0]  bcnt_q;
  logic        last_q;
  logic        ldp_q;
  logic        shp_q;
  logic        busy_q;
  logic        done_q;
  logic [4:0]  w_sum;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      q_q     <= 4'd0;
      m_q     <= 4'd0;
      bcnt_q  <= 2'd0;
      last_q  <= 1'b0;
      ldp_q   <= 1'b0;
      shp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ldp_q  <= 1'b0;
      shp_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            q_q     <= mplr;
            m_q     <= mcand;
            bcnt_q  <= 2'd0;
            last_q  <= 1'b0;
            ldp_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_INIT;
          end
        end
        S_INIT: state_q <= S_WAIT;
        S_WAIT: begin
          if (last_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ldp_q   <= q_q[0];
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          shp_q   <= 1'b1;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          q_q     <= q_q >> 1;
          bcnt_q  <= bcnt_q + 2'd1;
          // bcnt wraps to 0 here, so the final pass is remembered separately
          last_q  <= (bcnt_q == 2'd3);
          state_q <= S_WAIT;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign w_sum = {1'b0, acc_hi} + {1'b0, m_q};
  assign p_in  = (state_q == S_ADD) ? w_sum[3:0] : 4'd0;
  assign c_in  = (state_q == S_ADD) ? w_sum[4] : 1'b0;
  assign ldp   = ldp_q;
  assign shp   = shp_q;
  assign busy  = busy_q;
  assign done  = done_q;

`ifdef MULT_CTRL_START_ERR_EN
  logic start_err_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      start_err_q <= 1'b0;
    end else begin
      start_err_q <= start && (state_q != S_IDLE);
    end
  end

  assign start_err = start_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mult_ctrl: directed bench with product-register model/scoreboard.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mult_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [3:0] mplr = 4'd0;
  logic [3:0] mcand = 4'd0;
  logic [3:0] acc_hi;
  logic       ldp, shp, c_in, busy, done;
  logic [3:0] p_in;
`ifdef MULT_CTRL_START_ERR_EN
  logic       start_err;
`endif

  logic [8:0] preg;
  logic [7:0] prod_out;
  int         checks = 0;
  int         failures = 0;
  int         done_total = 0;
  int         exp_q[$];

  always #5 clk = ~clk;

  mult_ctrl dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .mplr   (mplr),
    .mcand  (mcand),
    .acc_hi (acc_hi),
    .ldp    (ldp),
    .shp    (shp),
    .p_in   (p_in),
    .c_in   (c_in),
    .busy   (busy),
    .done   (done)
`ifdef MULT_CTRL_START_ERR_EN
    ,
    .start_err (start_err)
`endif
  );

  // External product register: {carry, high, low}, output lags by a cycle
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      preg     <= 9'd0;
      prod_out <= 8'd0;
    end else begin
      prod_out <= preg[7:0];
      if (ldp)      preg[8:4] <= {c_in, p_in};
      else if (shp) preg      <= {c_in, preg[8:1]};
    end
  end

  assign acc_hi = prod_out[7:4];

  always @(negedge clk) if (done) done_total++;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_mult(input logic [3:0] a, input logic [3:0] b,
                          input bit hold, input bit repulse, input int abort_at);
    int k;
    logic [4:0] s;
    bit got;
    int errs;
    mplr  = a;
    mcand = b;
    start = 1'b1;
    exp_q.push_back(int'(a) * int'(b));
    got  = 1'b0;
    errs = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("ldp_shp_excl", 9'(ldp & shp), 9'd0);
      if (c <= 15) chk("busy", 9'(busy), 9'd1);
      else         chk("idle_busy", 9'(busy), 9'd0);
      chk("done_cycle", 9'(done), 9'(c == 15));
      case (c)
        1: begin
          chk("init_ldp", 9'(ldp), 9'd1);
          chk("init_pin", 9'({c_in, p_in}), 9'd0);
        end
        3, 6, 9, 12: begin
          k = (c - 3) / 3;
          chk("add_ldp", 9'(ldp), 9'(a[k]));
          if (a[k]) begin
            s = {1'b0, acc_hi} + {1'b0, b};
            chk("add_sum", 9'({c_in, p_in}), 9'(s));
          end
          chk("add_shp", 9'(shp), 9'd0);
        end
        4, 7, 10, 13: begin
          chk("shift_shp", 9'(shp), 9'd1);
          chk("shift_cin", 9'(c_in), 9'd0);
        end
        2, 5, 8, 11, 14: chk("wait_strobes", 9'({ldp, shp}), 9'd0);
        default: ;
      endcase
      if (done) begin
        got = 1'b1;
        chk("product", 9'(prod_out), 9'(exp_q.pop_front()));
      end
`ifdef MULT_CTRL_START_ERR_EN
      if (start_err) errs++;
`endif
      if (c == abort_at) begin
        clr = 1'b1;
        #1;
        chk("abort_outs", {ldp, shp, done, busy, c_in, p_in}, 9'd0);
        void'(exp_q.pop_front());
        return;
      end
      start = hold || (repulse && (c == 3 || c == 14));
    end
    if (!got) begin
      chk("done_seen", 9'd0, 9'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
`ifdef MULT_CTRL_START_ERR_EN
    if (repulse) chk("start_err_cnt", 9'(errs), 9'd2);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("reset_outs", {ldp, shp, done, busy, c_in, p_in}, 9'd0);
    clr   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 9'({busy, done, ldp}), 9'd0);

    run_mult(4'd13, 4'd11, 1'b0, 1'b0, 0);
    run_mult(4'd15, 4'd15, 1'b0, 1'b0, 0);
    run_mult(4'd0,  4'd9,  1'b0, 1'b0, 0);
    run_mult(4'd9,  4'd0,  1'b0, 1'b0, 0);
    run_mult(4'd6,  4'd7,  1'b0, 1'b1, 0);

    run_mult(4'd13, 4'd11, 1'b0, 1'b0, 8);
    mplr  = 4'd5;
    mcand = 4'd3;
    start = 1'b1;
    @(negedge clk);
    chk("clr_held_outs", {ldp, shp, done, busy, c_in, p_in}, 9'd0);
    clr = 1'b0;
    run_mult(4'd5, 4'd3, 1'b0, 1'b0, 0);

    run_mult(4'd2, 4'd3, 1'b1, 1'b0, 0);
    run_mult(4'd4, 4'd4, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    #1;
    chk("done_total", 9'(done_total), 9'd8);
    chk("scoreboard_empty", 9'(exp_q.size()), 9'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first (name  direction  width  meaning):
REQ-002 clk  input  1  clock, all state changes on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high; also drives the product register's clr.
REQ-004 start  input  1  request a new 4x4 unsigned multiply; sampled only in IDLE.
REQ-005 mplr  input  4  multiplier, captured when start is accepted.
REQ-006 mcand  input  4  multiplicand, captured when start is accepted.
REQ-007 acc_hi  input  4  high nibble of the product register output (prod_out[7:4]), lagging that register's internal state by one cycle.
REQ-008 ldp  output  1  load strobe to the product register, registered.
REQ-009 shp  output  1  shift strobe to the product register, registered.
REQ-010 p_in  output  4  addend sum to the product register, combinational from state, acc_hi and the captured multiplicand.
REQ-011 c_in  output  1  carry or shift-in bit to the product register.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; prod_out holds the final product in this cycle.

Function
REQ-014 SHALL implement the states IDLE, INIT, WAIT, ADD, SHIFT and DONE, with a 2-bit bit counter bcnt and 4-bit registers q (multiplier) and m (multiplicand).
REQ-015 IDLE with start=1 SHALL capture q<=mplr, m<=mcand and bcnt<=0, then go to INIT; start=0 keeps IDLE.
REQ-016 INIT SHALL assert ldp with p_in=0 and c_in=0, clearing the high product, then go to WAIT.
REQ-017 WAIT SHALL hold ldp=0 and shp=0 for exactly 1 cycle so acc_hi is valid; it then goes to ADD, or to DONE if the previous SHIFT was the 4th.
REQ-018 ADD SHALL assert ldp with {c_in,p_in}=acc_hi+m (5-bit) when q[0]=1; ldp=0 when q[0]=0; it always goes to SHIFT.
REQ-019 SHIFT SHALL assert shp with c_in=0, set q<=q>>1 and bcnt<=bcnt+1, then go to WAIT.
REQ-020 DONE SHALL pulse done for one cycle and go to IDLE; start is ignored in DONE.
REQ-021 Latency SHALL be fixed: start accepted at edge 0, INIT in cycle 1, done in cycle 15 (INIT + WAIT + 4 x (ADD, SHIFT, WAIT) + DONE), independent of operand values.
REQ-022 ldp and shp SHALL never be high in the same cycle.
REQ-023 start asserted while busy=1 SHALL be ignored, with no effect on q, m or the sequence.
REQ-024 bcnt SHALL wrap from 3 to 0 on the 4th SHIFT; the 4th-shift condition is held in a flag and not derived from bcnt=0 alone.
REQ-025 When clr is deasserted with start already high, start SHALL be accepted on the first rising edge after release.

Reset
REQ-026 While clr=1: state=IDLE, q=0, m=0, bcnt=0, ldp=0, shp=0, done=0, busy=0, c_in=0, p_in=0, taking effect immediately without a clock.
REQ-027 clr asserted mid-operation SHALL abort the multiply; no done pulse is produced for the aborted operation.

Configuration
REQ-028 Macro MULT_CTRL_START_ERR_EN SHALL add output port start_err (1 bit, registered) that pulses for one cycle when start=1 in any state other than IDLE; start_err is reset to 0 by clr.
REQ-029 Without MULT_CTRL_START_ERR_EN, the start_err port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 mplr=13, mcand=11, pulse start -> done in cycle 15; prod_out=0x8F (143) in the done cycle.
REQ-031 mplr=15, mcand=15 -> prod_out=0xE1 (225); ldp high in all 4 ADD states, each with c_in reflecting the adder carry.
REQ-032 mplr=0, mcand=9 -> no ldp after INIT, 4 shp pulses, prod_out=0x00 at done; then mplr=9, mcand=0 -> prod_out=0x00.
REQ-033 start re-pulsed in cycles 3 and 14 of a 6x7 run -> a single done in cycle 15, prod_out=0x2A; with MULT_CTRL_START_ERR_EN, start_err pulses twice.
REQ-034 clr pulsed in cycle 8 of a 13x11 run -> all outputs 0 immediately and no done; a new 5x3 run then gives prod_out=0x0F.
REQ-035 Back-to-back runs: start held high continuously -> runs 2x3 then 4x4 accepted 16 cycles apart -> 0x06, then 0x10.
